dds_sweep_ctrl: RTL and testbench

- Upstream configuration sequencer for the DDS wrapper. Generates a linear frequency sweep (chirp) by emitting phase-increment/phase-offset words with a one-cycle config strobe.
- Outputs o_pinc, o_poff and o_cfg_valid connect directly to the DDS wrapper inputs i_pinc, i_poff and i_cfg_valid.
- Supports single-shot and continuous (wrap-to-start) sweeps, a programmable dwell per step, and abort.

---
 rtl/dds_pkg.sv | 25 ++
 rtl/dds_sweep_next.sv | 26 ++
 rtl/dds_sweep_ctrl.sv | 109 ++++++++++
 tb/tb_dds_sweep_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types for DDS configuration sequencers: sweep FSM states and the
// shadow copy of a sweep request.
package dds_pkg;

    localparam int DDS_PHASE_W = 16;
    localparam int DDS_DWELL_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DWELL
    } sweep_state_t;

    // dwell is stored already normalised (never 0)
    typedef struct packed {
        logic [DDS_PHASE_W-1:0] start;
        logic [DDS_PHASE_W-1:0] stop;
        logic [DDS_PHASE_W-1:0] step;
        logic [DDS_DWELL_W-1:0] dwell;
        logic [DDS_PHASE_W-1:0] poff;
        logic                   continuous;
        logic                   dir_down;
    } sweep_cfg_t;

endpackage

// File: rtl/dds_sweep_next.sv
// Next sweep value: one step toward stop, clamped to stop on overshoot or
// on carry/borrow out of the W-bit range.
module dds_sweep_next #(
    parameter int W = 16
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] stop,
    input  logic [W-1:0] step,
    input  logic         dir_down,
    output logic [W-1:0] nxt
);

    logic [W:0] sum;
    logic [W:0] diff;

    assign sum  = {1'b0, cur} + {1'b0, step};
    assign diff = {1'b0, cur} - {1'b0, step};

    always_comb begin
        if (dir_down)
            nxt = (diff[W] || (diff[W-1:0] < stop)) ? stop : diff[W-1:0];
        else
            nxt = (sum[W] || (sum[W-1:0] > stop)) ? stop : sum[W-1:0];
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear chirp sequencer: writes pinc/poff to the DDS every D cycles from
// start to stop, single-shot or wrapping, with abort.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int PHASE_W = DDS_PHASE_W,
    parameter int DWELL_W = DDS_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_continuous,
    input  logic [PHASE_W-1:0] i_start_pinc,
    input  logic [PHASE_W-1:0] i_stop_pinc,
    input  logic [PHASE_W-1:0] i_step,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [PHASE_W-1:0] i_poff,
    output logic [PHASE_W-1:0] o_pinc,
    output logic [PHASE_W-1:0] o_poff,
    output logic               o_cfg_valid,
    output logic               o_busy,
    output logic               o_done
);

    sweep_state_t       state_q, state_d;
    sweep_cfg_t         cfg_q, cfg_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [PHASE_W-1:0] pinc_d, poff_d, nxt;
    logic               valid_d, busy_d, done_d;
    logic               accept, last, step_end, wrap, finish;

    dds_sweep_next #(.W(PHASE_W)) u_next (
        .cur      (o_pinc),
        .stop     (cfg_q.stop),
        .step     (cfg_q.step),
        .dir_down (cfg_q.dir_down),
        .nxt      (nxt)
    );

    assign accept   = (state_q == IDLE) && i_start && !i_abort;
    assign last     = (o_pinc == cfg_q.stop) || (cfg_q.step == '0);
    // the current write's D-cycle slot ends this cycle
    assign step_end = ((state_q == EMIT) && (cfg_q.dwell == DWELL_W'(1))) ||
                      ((state_q == DWELL) && (cnt_q == DWELL_W'(1)));
    assign wrap     = last && cfg_q.continuous && (cfg_q.step != '0);
    assign finish   = step_end && last && !wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            cnt_q       <= '0;
            o_pinc      <= '0;
            o_poff      <= '0;
            o_cfg_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            cnt_q       <= cnt_d;
            o_pinc      <= pinc_d;
            o_poff      <= poff_d;
            o_cfg_valid <= valid_d;
            o_busy      <= busy_d;
            o_done      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EMIT;
            EMIT:    state_d = step_end ? (finish ? IDLE : EMIT) : DWELL;
            DWELL:   if (step_end) state_d = finish ? IDLE : EMIT;
            default: state_d = IDLE;
        endcase
        if (i_abort)
            state_d = IDLE;
    end

    always_comb begin
        cfg_d   = cfg_q;
        cnt_d   = '0;
        pinc_d  = o_pinc;
        poff_d  = o_poff;
        valid_d = (state_d == EMIT);
        busy_d  = (state_d != IDLE);
        done_d  = finish && !i_abort;
        if (accept) begin
            cfg_d.start      = i_start_pinc;
            cfg_d.stop       = i_stop_pinc;
            cfg_d.step       = i_step;
            cfg_d.dwell      = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
            cfg_d.poff       = i_poff;
            cfg_d.continuous = i_continuous;
            cfg_d.dir_down   = (i_stop_pinc < i_start_pinc);
            pinc_d           = i_start_pinc;
            poff_d           = i_poff;
        end else if (state_d == EMIT) begin
            pinc_d = wrap ? cfg_q.start : nxt;
            poff_d = cfg_q.poff;
        end
        if (state_d == DWELL)
            cnt_d = (state_q == EMIT) ? cfg_q.dwell - DWELL_W'(1) : cnt_q - DWELL_W'(1);
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: table of sweeps with hand-computed
// write sequences, plus abort / reset / start-while-busy sequences.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_abort, i_continuous;
    logic [15:0] i_start_pinc, i_stop_pinc, i_step, i_poff;
    logic [23:0] i_dwell;
    logic [15:0] o_pinc, o_poff;
    logic        o_cfg_valid, o_busy, o_done;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dds_sweep_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_continuous (i_continuous),
        .i_start_pinc (i_start_pinc),
        .i_stop_pinc  (i_stop_pinc),
        .i_step       (i_step),
        .i_dwell      (i_dwell),
        .i_poff       (i_poff),
        .o_pinc       (o_pinc),
        .o_poff       (o_poff),
        .o_cfg_valid  (o_cfg_valid),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    typedef struct {
        logic [15:0]       start, stop, step, poff;
        logic [23:0]       dwell;
        logic              cont;
        int                n_emit;
        int                d_eff;
        logic              exp_done;
        logic              poke;
        logic [5:0][15:0]  pinc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_cfg(input vec_t v);
        i_start_pinc = v.start;
        i_stop_pinc  = v.stop;
        i_step       = v.step;
        i_dwell      = v.dwell;
        i_poff       = v.poff;
        i_continuous = v.cont;
    endtask

    function automatic vec_t mk(input logic [15:0] s, input logic [15:0] e, input logic [15:0] st,
                                input logic [23:0] dw, input logic c, input int n, input int d,
                                input logic dn, input logic pk, input logic [15:0] po,
                                input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                                input logic [15:0] p3, input logic [15:0] p4);
        vec_t v;
        v.start = s; v.stop = e; v.step = st; v.dwell = dw; v.cont = c;
        v.n_emit = n; v.d_eff = d; v.exp_done = dn; v.poke = pk; v.poff = po;
        v.pinc[0] = p0; v.pinc[1] = p1; v.pinc[2] = p2; v.pinc[3] = p3; v.pinc[4] = p4;
        v.pinc[5] = 16'h0;
        return v;
    endfunction

    // Cycle 1 is the first cycle after the one in which i_start is high.
    task automatic run_vec(input vec_t v, input int idx);
        int win;
        int k;
        logic exp_v;
        win = v.n_emit * v.d_eff + (v.exp_done ? 1 : 0);
        @(posedge clk); #1;
        drive_cfg(v);
        i_start = 1'b1;
        for (int cyc = 1; cyc <= win; cyc++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            if (v.poke && cyc == 2) begin
                i_start      = 1'b1;
                i_start_pinc = 16'h0F00;
                i_step       = 16'h0001;
                i_poff       = 16'hDEAD;
            end
            @(negedge clk);
            k     = (cyc - 1) / v.d_eff;
            exp_v = ((cyc - 1) % v.d_eff == 0) && (k < v.n_emit);
            chk($sformatf("v%0d c%0d cfg_valid", idx, cyc), {31'b0, o_cfg_valid}, {31'b0, exp_v});
            if (exp_v) begin
                chk($sformatf("v%0d c%0d pinc", idx, cyc), {16'b0, o_pinc}, {16'b0, v.pinc[k]});
                chk($sformatf("v%0d c%0d poff", idx, cyc), {16'b0, o_poff}, {16'b0, v.poff});
            end
            chk($sformatf("v%0d c%0d done", idx, cyc), {31'b0, o_done},
                {31'b0, v.exp_done && cyc == win});
            chk($sformatf("v%0d c%0d busy", idx, cyc), {31'b0, o_busy},
                {31'b0, !(v.exp_done && cyc == win)});
        end
        if (v.cont) begin
            // abort mid-dwell: idle next cycle, outputs hold the last write
            i_abort = 1'b1;
            @(posedge clk); #1;
            i_abort = 1'b0;
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                chk($sformatf("v%0d abort%0d busy", idx, j), {31'b0, o_busy}, 32'd0);
                chk($sformatf("v%0d abort%0d valid", idx, j), {31'b0, o_cfg_valid}, 32'd0);
                chk($sformatf("v%0d abort%0d done", idx, j), {31'b0, o_done}, 32'd0);
                chk($sformatf("v%0d abort%0d pinc", idx, j), {16'b0, o_pinc},
                    {16'b0, v.pinc[v.n_emit-1]});
                @(posedge clk);
            end
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        vec_t v1;
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_continuous = 1'b0;
        i_start_pinc = '0; i_stop_pinc = '0; i_step = '0; i_dwell = '0; i_poff = '0;

        //          start     stop      step      dw cont n d done poke poff      p0        p1        p2        p3        p4
        vecs[0] = mk(16'h0100, 16'h0400, 16'h0100, 4, 0, 4, 4, 1, 1, 16'h1111, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0);
        vecs[1] = mk(16'h0500, 16'h0080, 16'h0200, 1, 0, 4, 1, 1, 0, 16'h2222, 16'h0500, 16'h0300, 16'h0100, 16'h0080, 16'h0);
        vecs[2] = mk(16'hFF00, 16'hFFFF, 16'h00C0, 2, 0, 3, 2, 1, 0, 16'h3333, 16'hFF00, 16'hFFC0, 16'hFFFF, 16'h0,    16'h0);
        vecs[3] = mk(16'h0010, 16'h0030, 16'h0010, 2, 1, 5, 2, 0, 0, 16'h4444, 16'h0010, 16'h0020, 16'h0030, 16'h0010, 16'h0020);
        vecs[4] = mk(16'h0001, 16'h0003, 16'h0001, 0, 0, 3, 1, 1, 0, 16'h5555, 16'h0001, 16'h0002, 16'h0003, 16'h0,    16'h0);
        vecs[5] = mk(16'h0700, 16'h0900, 16'h0000, 1, 1, 1, 1, 1, 0, 16'h6666, 16'h0700, 16'h0,    16'h0,    16'h0,    16'h0);
        vecs[6] = mk(16'h0200, 16'h0200, 16'h0005, 3, 0, 1, 3, 1, 0, 16'h7777, 16'h0200, 16'h0,    16'h0,    16'h0,    16'h0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset pinc", {16'b0, o_pinc}, 32'd0);
        chk("reset poff", {16'b0, o_poff}, 32'd0);
        chk("reset valid", {31'b0, o_cfg_valid}, 32'd0);
        chk("reset busy", {31'b0, o_busy}, 32'd0);
        chk("reset done", {31'b0, o_done}, 32'd0);

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], i);

        // start and abort together in IDLE: nothing starts
        @(posedge clk); #1;
        drive_cfg(vecs[0]);
        i_start = 1'b1; i_abort = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_abort = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("start+abort c%0d busy", j), {31'b0, o_busy}, 32'd0);
            chk($sformatf("start+abort c%0d valid", j), {31'b0, o_cfg_valid}, 32'd0);
        end

        // reset at the second write, then a clean rerun of the first sweep
        v1 = vecs[0];
        v1.poke = 1'b0;
        @(posedge clk); #1;
        drive_cfg(v1);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst seq 2nd emit valid", {31'b0, o_cfg_valid}, 32'd1);
        chk("rst seq 2nd emit pinc", {16'b0, o_pinc}, 32'h0200);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst seq pinc", {16'b0, o_pinc}, 32'd0);
        chk("rst seq poff", {16'b0, o_poff}, 32'd0);
        chk("rst seq valid", {31'b0, o_cfg_valid}, 32'd0);
        chk("rst seq busy", {31'b0, o_busy}, 32'd0);
        chk("rst seq done", {31'b0, o_done}, 32'd0);
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            chk($sformatf("rst seq idle c%0d done", j), {31'b0, o_done}, 32'd0);
            chk($sformatf("rst seq idle c%0d valid", j), {31'b0, o_cfg_valid}, 32'd0);
        end
        run_vec(v1, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
